varredura_matriz_leds: RTL and testbench
========================================

// Module: varredura_matriz_leds
// PURPOSE
//  Time-multiplexed driver for the 5-column x 7-row LED matrix. It sits directly downstream of the
//  attack manager and consumes its matriz0..matriz4 revealed-hit bitmap and the current cursor
//  coordinates. It scans one column at a time, drives row lines from the selected column word, and
//  overlays a blinking cursor on the addressed cell.
// PARAMETERS
//  DIV_SCAN      5000  clock cycles each column is displayed; legal range >= 2
//  BLINK_FRAMES  50    full scan frames per cursor blink half-period; legal range >= 1
// PORTS
//  clock        in   1  system clock; all state updates on its rising edge
//  reset        in   1  asynchronous, active-high reset
//  enable       in   1  1 = scan; 0 = blank display and hold counters cleared (synchronous)
//  matriz0..4   in   7  column words from the attack manager; bit r = row r, 1 = LED on
//  coordColuna  in   3  cursor column, valid range 0..4
//  coordLinha   in   3  cursor row, valid range 0..6
//  colunas      out  5  column strobes, one-hot, active-LOW; 5'b11111 = all off
//  linhas       out  7  row drive, active-HIGH
//  frame_tick   out  1  one-cycle pulse at the start of each frame
// BEHAVIOUR
//  Reset values: colunas=5'b11111, linhas=0, frame_tick=0; internal prescaler=0, col_idx=0,
//    blink_cnt=0, blink_phase=0.
//  enable=0: next edge loads the reset values synchronously. Outputs stay blank while enable=0.
//  Prescaler: counts 0..DIV_SCAN-1. At DIV_SCAN-1 it wraps to 0 and col_idx advances.
//    col_idx sequence is 0,1,2,3,4,0; 4 wraps to 0.
//  Outputs are registered and lag col_idx by one cycle.
//    colunas = ~(5'b00001 << col_idx); linhas = overlay(matriz[col_idx]).
//  After reset release with enable=1:
//    first edge      colunas=11110 (column 0)
//    column 1 shown  from edge DIV_SCAN+1
//    result          each column is lit for exactly DIV_SCAN cycles
//  frame_tick: 1 in exactly the cycle where colunas shows column 0 from a 4->0 wrap.
//    It is NOT asserted for the first column 0 after reset or enable.
//  Blink: blink_cnt counts frame wraps 0..BLINK_FRAMES-1. At terminal count it returns to 0 and
//    blink_phase toggles.
//  Matrix inputs: sampled combinationally into the output register, so a change is visible on the
//    next edge if its column is active.
//  Coordinates out of range (coordColuna>4 or coordLinha>6): no overlay is applied.
//  Reset asserted mid-frame: outputs blank immediately (asynchronous); no partial state survives.
// CONFIGURATION
//  CURSOR_BLINK_EN defined:
//    - in the cursor column, linhas[coordLinha] = matriz bit XOR blink_phase
//    - the cursor cell therefore inverts every BLINK_FRAMES frames
//  CURSOR_BLINK_EN undefined:
//    - no overlay; blink counter and blink_phase are not built
//    - linhas = matriz[col_idx] exactly; BLINK_FRAMES is ignored
// STRUCTURE
//  Shared package jogo_pkg:
//    - NUM_COLS=5, NUM_ROWS=7, COL_W=3
//    - COLS_OFF=5'b11111
//  Sub-module contador_modulo (parameters N, WIDTH; ports clock, reset, clr, inc, count, tc):
//    - generic mod-N counter with terminal-count flag
//    - instantiated for the prescaler, col_idx and (under CURSOR_BLINK_EN) blink_cnt
// TESTING  (DIV_SCAN=4, BLINK_FRAMES=2)
//  1. reset=1 -> colunas=11111, linhas=0, frame_tick=0; hold for 3 cycles with enable=1, no change.
//  2. Release reset, enable=1, matriz0=7'b1110001, matriz4=7'b1110000, others 0, coord (7,7):
//     colunas = 11110 x4, 11101 x4, 11011 x4, 10111 x4, 01111 x4, 11110.
//     linhas = 1110001 with column 0 and 1110000 with column 4.
//     frame_tick=1 only on the second 11110 cycle.
//  3. CURSOR_BLINK_EN defined, coord (col 1,row 5), matriz1=0:
//     - frames 1-2: linhas in column 1 = 0000000
//     - frames 3-4: linhas in column 1 = 0100000
//     - frames 5-6: 0000000 again
//     With matriz1=7'b0100000 the phases invert.
//  4. CURSOR_BLINK_EN undefined, same stimulus as 3 -> column 1 linhas always equals matriz1.
//  5. Drop enable during column 3 -> next edge colunas=11111, linhas=0.
//     Re-raise enable -> column 0 is shown, with no frame_tick on that first frame.
//  6. Assert reset mid-column 2 between edges -> outputs blank immediately.
//     After release, the sequence restarts exactly as in scenario 2.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared constants for the LED-matrix game blocks: matrix geometry, blank column pattern
// and the counter-width helper.
package jogo_pkg;

  localparam int unsigned NUM_COLS  = 5;
  localparam int unsigned NUM_ROWS  = 7;
  localparam int unsigned COL_W     = 3;
  localparam int unsigned ROW_IDX_W = 3;

  localparam logic [NUM_COLS-1:0] COLS_OFF = 5'b11111;

  // Counter width for a mod-n counter; never zero so n = 1 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/varredura_matriz_leds_if.sv
// Bundle between the attack manager / cursor logic and the LED matrix scanner.
// master drives bitmap, cursor and enable; slave (the scanner) drives the matrix lines.
interface varredura_matriz_leds_if;
  import jogo_pkg::*;

  logic                  enable;
  logic [NUM_ROWS-1:0]   matriz0;
  logic [NUM_ROWS-1:0]   matriz1;
  logic [NUM_ROWS-1:0]   matriz2;
  logic [NUM_ROWS-1:0]   matriz3;
  logic [NUM_ROWS-1:0]   matriz4;
  logic [COL_W-1:0]      coordColuna;
  logic [ROW_IDX_W-1:0]  coordLinha;
  logic [NUM_COLS-1:0]   colunas;
  logic [NUM_ROWS-1:0]   linhas;
  logic                  frame_tick;

  modport master (
    output enable, matriz0, matriz1, matriz2, matriz3, matriz4, coordColuna, coordLinha,
    input  colunas, linhas, frame_tick
  );

  modport slave (
    input  enable, matriz0, matriz1, matriz2, matriz3, matriz4, coordColuna, coordLinha,
    output colunas, linhas, frame_tick
  );

endinterface

// File: rtl/contador_modulo.sv
// Generic mod-N counter: synchronous clear has priority over increment; tc flags count == N-1.
module contador_modulo #(
  parameter int unsigned N     = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign tc    = (r_count == LAST);

endmodule

// File: rtl/varredura_matriz_leds.sv
// Column-scanning driver for the 5x7 LED matrix with optional blinking cursor overlay.
// Define CURSOR_BLINK_EN to build the blink counter and XOR the cursor cell with blink phase.
module varredura_matriz_leds
  import jogo_pkg::*;
#(
  parameter int unsigned DIV_SCAN     = 5000,
  parameter int unsigned BLINK_FRAMES = 50
) (
  input  logic                   clock,
  input  logic                   reset,
  varredura_matriz_leds_if.slave bus
);

  localparam int unsigned PRE_W = cnt_width(DIV_SCAN);

  logic [PRE_W-1:0]    w_presc;
  logic                w_presc_tc;
  logic [COL_W-1:0]    w_col;
  logic                w_col_tc;
  logic                w_clr;
  logic                w_col_inc;
  logic                w_frame_wrap;
  logic                w_frame_tick_d;
  logic [NUM_ROWS-1:0] w_col_word;
  logic [NUM_ROWS-1:0] w_linhas_d;

  logic [NUM_COLS-1:0] r_colunas;
  logic [NUM_ROWS-1:0] r_linhas;
  logic                r_frame_tick;
  logic                r_frame_seen;

  assign w_clr        = ~bus.enable;
  assign w_col_inc    = bus.enable & w_presc_tc;
  assign w_frame_wrap = w_col_inc & w_col_tc;

  contador_modulo #(.N(DIV_SCAN), .WIDTH(PRE_W)) u_presc (
    .clock (clock),
    .reset (reset),
    .clr   (w_clr),
    .inc   (bus.enable),
    .count (w_presc),
    .tc    (w_presc_tc)
  );

  contador_modulo #(.N(NUM_COLS), .WIDTH(COL_W)) u_col (
    .clock (clock),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_col_inc),
    .count (w_col),
    .tc    (w_col_tc)
  );

  always_comb begin
    w_col_word = '0;
    case (w_col)
      3'd0:    w_col_word = bus.matriz0;
      3'd1:    w_col_word = bus.matriz1;
      3'd2:    w_col_word = bus.matriz2;
      3'd3:    w_col_word = bus.matriz3;
      3'd4:    w_col_word = bus.matriz4;
      default: w_col_word = '0;
    endcase
  end

`ifdef CURSOR_BLINK_EN
  localparam int unsigned BLK_W = cnt_width(BLINK_FRAMES);

  logic [BLK_W-1:0] w_unused_blink_cnt;
  logic             w_blink_tc;
  logic             w_in_range;
  logic             r_blink_phase;

  contador_modulo #(.N(BLINK_FRAMES), .WIDTH(BLK_W)) u_blink (
    .clock (clock),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_frame_wrap),
    .count (w_unused_blink_cnt),
    .tc    (w_blink_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_blink_phase <= 1'b0;
    end else if (!bus.enable) begin
      r_blink_phase <= 1'b0;
    end else if (w_frame_wrap && w_blink_tc) begin
      r_blink_phase <= ~r_blink_phase;
    end
  end

  assign w_in_range = (bus.coordColuna < COL_W'(NUM_COLS)) &&
                      (bus.coordLinha < ROW_IDX_W'(NUM_ROWS));

  always_comb begin
    w_linhas_d = w_col_word;
    if (w_in_range && (bus.coordColuna == w_col)) begin
      w_linhas_d[bus.coordLinha] = w_col_word[bus.coordLinha] ^ r_blink_phase;
    end
  end
`else
  logic w_unused_coord;

  assign w_unused_coord = ^{bus.coordColuna, bus.coordLinha};
  assign w_linhas_d     = w_col_word;
`endif

  // col 0 with a cleared prescaler recurs only at frame starts; r_frame_seen masks the first one.
  assign w_frame_tick_d = r_frame_seen && (w_col == '0) && (w_presc == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_colunas    <= COLS_OFF;
      r_linhas     <= '0;
      r_frame_tick <= 1'b0;
      r_frame_seen <= 1'b0;
    end else if (!bus.enable) begin
      r_colunas    <= COLS_OFF;
      r_linhas     <= '0;
      r_frame_tick <= 1'b0;
      r_frame_seen <= 1'b0;
    end else begin
      r_colunas    <= ~(NUM_COLS'(1) << w_col);
      r_linhas     <= w_linhas_d;
      r_frame_tick <= w_frame_tick_d;
      if (w_frame_wrap) begin
        r_frame_seen <= 1'b1;
      end
    end
  end

  assign bus.colunas    = r_colunas;
  assign bus.linhas     = r_linhas;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_varredura_matriz_leds.sv
// Self-checking bench for varredura_matriz_leds (DIV_SCAN=4, BLINK_FRAMES=2) using an
// expected-output queue filled per cycle from a cycle-index reference model.
module tb_varredura_matriz_leds;

  localparam int DIV = 4;
  localparam int BF  = 2;

  typedef struct packed {
    logic [4:0] col;
    logic [6:0] lin;
    logic       ft;
  } exp_t;

  logic clock;
  logic reset;
  varredura_matriz_leds_if bus ();

  varredura_matriz_leds #(.DIV_SCAN(DIV), .BLINK_FRAMES(BF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [6:0] tb_m[5];
  int   tb_cc;
  int   tb_cl;

  // Expected outputs k cycles after scanning starts (k = 1 is the first edge).
  function automatic exp_t model(input int k);
    exp_t       e;
    logic [4:0] one;
    logic [6:0] lin;
    int         col;
    int         frame;
    one   = 5'b00001;
    col   = ((k - 1) / DIV) % 5;
    frame = (k - 1) / (5 * DIV);
    lin   = tb_m[col];
`ifdef CURSOR_BLINK_EN
    if (tb_cc <= 4 && tb_cl <= 6 && tb_cc == col) lin[tb_cl] = lin[tb_cl] ^ ((frame / BF) % 2 == 1);
`endif
    e.col = ~(one << col);
    e.lin = lin;
    e.ft  = (k > 1) && ((k - 1) % (5 * DIV) == 0);
    return e;
  endfunction

  task automatic drive_inputs();
    bus.matriz0     = tb_m[0];
    bus.matriz1     = tb_m[1];
    bus.matriz2     = tb_m[2];
    bus.matriz3     = tb_m[3];
    bus.matriz4     = tb_m[4];
    bus.coordColuna = 3'(tb_cc);
    bus.coordLinha  = 3'(tb_cl);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got;
    exp_t e;
    e = '{col: 5'b11111, lin: 7'd0, ft: 1'b0};
    reset      = 1'b1;
    bus.enable = 1'b1;
    #1;
    got = '{col: bus.colunas, lin: bus.linhas, ft: bus.frame_tick};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_async got %b/%b/%b want %b/%b/%b", got.col, got.lin, got.ft,
               e.col, e.lin, e.ft);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      got = '{col: bus.colunas, lin: bus.linhas, ft: bus.frame_tick};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_hold[%0d] got %b/%b/%b want %b/%b/%b", i, got.col, got.lin,
                 got.ft, e.col, e.lin, e.ft);
      end
    end
  endtask

  task automatic test_scan();
    exp_t got;
    exp_t e;
    tb_m[0] = 7'b1110001; tb_m[1] = '0; tb_m[2] = '0; tb_m[3] = '0; tb_m[4] = 7'b1110000;
    tb_cc = 7; tb_cl = 7;
    drive_inputs();
    do_reset();
    for (int k = 1; k <= 21; k++) begin
      sb_q.push_back(model(k));
      @(posedge clock);
      #1;
      e   = sb_q.pop_front();
      got = '{col: bus.colunas, lin: bus.linhas, ft: bus.frame_tick};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scan k=%0d got %b/%b/%b want %b/%b/%b", k, got.col, got.lin, got.ft,
                 e.col, e.lin, e.ft);
      end
    end
  endtask

  task automatic test_cursor();
    exp_t got;
    exp_t e;
    logic [6:0] m1_pat[2];
    m1_pat[0] = 7'b0000000;
    m1_pat[1] = 7'b0100000;
    for (int p = 0; p < 2; p++) begin
      tb_m[0] = 7'b0000011; tb_m[1] = m1_pat[p]; tb_m[2] = 7'b1000000; tb_m[3] = '0;
      tb_m[4] = 7'b0010100;
      tb_cc = 1; tb_cl = 5;
      drive_inputs();
      do_reset();
      for (int k = 1; k <= 6 * 5 * DIV; k++) begin
        sb_q.push_back(model(k));
        @(posedge clock);
        #1;
        e   = sb_q.pop_front();
        got = '{col: bus.colunas, lin: bus.linhas, ft: bus.frame_tick};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL cursor p=%0d k=%0d got %b/%b/%b want %b/%b/%b", p, k, got.col,
                   got.lin, got.ft, e.col, e.lin, e.ft);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    exp_t got;
    exp_t e;
    tb_m[0] = 7'b0101010; tb_m[1] = 7'b0000001; tb_m[2] = 7'b1111111; tb_m[3] = 7'b0011000;
    tb_m[4] = 7'b1000001;
    tb_cc = 7; tb_cl = 0;
    drive_inputs();
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      sb_q.push_back(model(k));
      @(posedge clock);
      #1;
      e   = sb_q.pop_front();
      got = '{col: bus.colunas, lin: bus.linhas, ft: bus.frame_tick};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL en_pre k=%0d got %b/%b/%b want %b/%b/%b", k, got.col, got.lin, got.ft,
                 e.col, e.lin, e.ft);
      end
    end
    bus.enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back('{col: 5'b11111, lin: 7'd0, ft: 1'b0});
      @(posedge clock);
      #1;
      e   = sb_q.pop_front();
      got = '{col: bus.colunas, lin: bus.linhas, ft: bus.frame_tick};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL en_low[%0d] got %b/%b/%b want %b/%b/%b", i, got.col, got.lin, got.ft,
                 e.col, e.lin, e.ft);
      end
    end
    bus.enable = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      sb_q.push_back(model(k));
      @(posedge clock);
      #1;
      e   = sb_q.pop_front();
      got = '{col: bus.colunas, lin: bus.linhas, ft: bus.frame_tick};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL en_resume k=%0d got %b/%b/%b want %b/%b/%b", k, got.col, got.lin,
                 got.ft, e.col, e.lin, e.ft);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t got;
    exp_t e;
    tb_m[0] = 7'b1110001; tb_m[1] = '0; tb_m[2] = 7'b0110110; tb_m[3] = '0; tb_m[4] = 7'b1110000;
    tb_cc = 7; tb_cl = 7;
    drive_inputs();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      sb_q.push_back(model(k));
      @(posedge clock);
      #1;
      e   = sb_q.pop_front();
      got = '{col: bus.colunas, lin: bus.linhas, ft: bus.frame_tick};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mid_pre k=%0d got %b/%b/%b want %b/%b/%b", k, got.col, got.lin, got.ft,
                 e.col, e.lin, e.ft);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    e   = '{col: 5'b11111, lin: 7'd0, ft: 1'b0};
    got = '{col: bus.colunas, lin: bus.linhas, ft: bus.frame_tick};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL mid_async got %b/%b/%b want %b/%b/%b", got.col, got.lin, got.ft,
               e.col, e.lin, e.ft);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      sb_q.push_back(model(k));
      @(posedge clock);
      #1;
      e   = sb_q.pop_front();
      got = '{col: bus.colunas, lin: bus.linhas, ft: bus.frame_tick};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mid_restart k=%0d got %b/%b/%b want %b/%b/%b", k, got.col, got.lin,
                 got.ft, e.col, e.lin, e.ft);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b0;
    for (int c = 0; c < 5; c++) tb_m[c] = '0;
    tb_cc = 7;
    tb_cl = 7;
    drive_inputs();
    test_reset();
    test_scan();
    test_cursor();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
